// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard controller.
// Entries carry rd zero-extended to MAX_REG_BITS so one struct serves every REG_BITS.
package fwd_pkg;

  localparam int DEF_REG_BITS = 5;
  localparam int MAX_REG_BITS = 8;

  typedef struct packed {
    logic                    valid;
    logic [MAX_REG_BITS-1:0] rd;
    logic                    regwrite;
    logic                    is_load;
  } entry_t;

  function automatic int fwd_selw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request / hazard-response bundle between the pipeline and fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if
  import fwd_pkg::*;
#(
  parameter int REG_BITS = DEF_REG_BITS,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 2
);
  localparam int SELW = fwd_selw(DEPTH);

  logic                         id_valid;
  logic [NUM_SRC*REG_BITS-1:0]  id_rs;
  logic [NUM_SRC-1:0]           id_rs_used;
  logic [REG_BITS-1:0]          id_rd;
  logic                         id_regwrite;
  logic                         id_is_load;
  logic                         flush;
  logic                         stall;
  logic [NUM_SRC*SELW-1:0]      fwd_sel;
  logic [15:0]                  stall_count;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, flush,
    input  stall, fwd_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, flush,
    output stall, fwd_sel, stall_count
  );

endinterface

// File: rtl/fwd_match.sv
// Per-source priority match: youngest in-flight writer of rs wins.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SELW  = 2
) (
  input  entry_t [DEPTH-1:0]      ents,
  input  logic [MAX_REG_BITS-1:0] rs,
  input  logic                    used,
  output logic [SELW-1:0]         sel,
  output logic                    is_load
);

  // Scan oldest to youngest so the lowest index overwrites any older hit.
  always_comb begin
    sel     = '0;
    is_load = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (used && ents[j].valid && ents[j].regwrite &&
          ents[j].rd != '0 && ents[j].rd == rs) begin
        sel     = SELW'(j + 1);
        is_load = ents[j].is_load;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall generation for an in-order pipeline.
// e[0] mirrors EX, e[k] mirrors forwarding stage k; e[DEPTH] is the write-back stage.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_BITS         = DEF_REG_BITS,
  parameter int NUM_SRC          = 2,
  parameter int DEPTH            = 2,
  parameter int LOAD_READY_STAGE = 2
) (
  input  logic             clk,
  input  logic             reset,
  fwd_hazard_ctrl_if.slave bus
);

  localparam int SELW = fwd_selw(DEPTH);

  entry_t [DEPTH:0]                e;
  entry_t                          id_ent;
  logic [NUM_SRC-1:0][SELW-1:0]    sel;
  logic [NUM_SRC-1:0][SELW-1:0]    fwd_sel_q;
  logic [NUM_SRC-1:0]              src_load;
  logic [NUM_SRC-1:0]              src_haz;
  logic [15:0]                     stall_count_q;
  logic                            hazard;
  logic                            stall;
  logic                            load;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [MAX_REG_BITS-1:0] rs_ext;
    assign rs_ext = MAX_REG_BITS'(bus.id_rs[s*REG_BITS +: REG_BITS]);

    fwd_match #(.DEPTH(DEPTH), .SELW(SELW)) u_match (
      .ents    (e[DEPTH-1:0]),
      .rs      (rs_ext),
      .used    (bus.id_rs_used[s]),
      .sel     (sel[s]),
      .is_load (src_load[s])
    );

    // Load data not yet available at the stage it currently occupies.
    assign src_haz[s] = src_load[s] && (int'(sel[s]) < LOAD_READY_STAGE);
  end

  assign hazard = |src_haz;
  assign stall  = bus.id_valid && hazard && !bus.flush;
  assign load   = bus.id_valid && !stall && !bus.flush;

  always_comb begin
    id_ent          = '0;
    id_ent.valid    = 1'b1;
    id_ent.rd       = MAX_REG_BITS'(bus.id_rd);
    id_ent.regwrite = bus.id_regwrite;
    id_ent.is_load  = bus.id_is_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e             <= '0;
      fwd_sel_q     <= '0;
      stall_count_q <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) e[k] <= e[k-1];
      e[0]      <= load ? id_ent : '0;
      fwd_sel_q <= load ? sel : '0;
      if (stall && stall_count_q != 16'hFFFF)
        stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_sel     = fwd_sel_q;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench: three configurations share one ID stream; a monitor checks queued expectations.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       flush;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int    cyc;
    int    d;
    string nm;
    int    st;
    int    s0;
    int    s1;
    int    c;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fwd_hazard_ctrl_if #(.REG_BITS(5), .NUM_SRC(2), .DEPTH(2)) if0 ();
  fwd_hazard_ctrl_if #(.REG_BITS(5), .NUM_SRC(2), .DEPTH(4)) if1 ();
  fwd_hazard_ctrl_if #(.REG_BITS(5), .NUM_SRC(2), .DEPTH(6)) if2 ();

  fwd_hazard_ctrl #(.REG_BITS(5), .NUM_SRC(2), .DEPTH(2), .LOAD_READY_STAGE(2))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  fwd_hazard_ctrl #(.REG_BITS(5), .NUM_SRC(2), .DEPTH(4), .LOAD_READY_STAGE(3))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  fwd_hazard_ctrl #(.REG_BITS(5), .NUM_SRC(2), .DEPTH(6), .LOAD_READY_STAGE(6))
    dut2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.id_valid = id_valid;     assign if1.id_valid = id_valid;     assign if2.id_valid = id_valid;
  assign if0.id_rs = id_rs;           assign if1.id_rs = id_rs;           assign if2.id_rs = id_rs;
  assign if0.id_rs_used = id_rs_used; assign if1.id_rs_used = id_rs_used; assign if2.id_rs_used = id_rs_used;
  assign if0.id_rd = id_rd;           assign if1.id_rd = id_rd;           assign if2.id_rd = id_rd;
  assign if0.id_regwrite = id_regwrite; assign if1.id_regwrite = id_regwrite; assign if2.id_regwrite = id_regwrite;
  assign if0.id_is_load = id_is_load; assign if1.id_is_load = id_is_load; assign if2.id_is_load = id_is_load;
  assign if0.flush = flush;           assign if1.flush = flush;           assign if2.flush = flush;

  int ost[3], os0[3], os1[3], ocnt[3];
  always_comb begin
    ost[0] = int'(if0.stall);  os0[0] = int'(if0.fwd_sel[1:0]); os1[0] = int'(if0.fwd_sel[3:2]);
    ost[1] = int'(if1.stall);  os0[1] = int'(if1.fwd_sel[2:0]); os1[1] = int'(if1.fwd_sel[5:3]);
    ost[2] = int'(if2.stall);  os0[2] = int'(if2.fwd_sel[2:0]); os1[2] = int'(if2.fwd_sel[5:3]);
    ocnt[0] = int'(if0.stall_count);
    ocnt[1] = int'(if1.stall_count);
    ocnt[2] = int'(if2.stall_count);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                       input int rd, input bit rw, input bit ld, input bit fl);
    id_valid    = v;
    id_rs[4:0]  = rs0[4:0];
    id_rs[9:5]  = rs1[4:0];
    id_rs_used  = used;
    id_rd       = rd[4:0];
    id_regwrite = rw;
    id_is_load  = ld;
    flush       = fl;
  endtask

  task automatic bubble();
    instr(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Negative values mean "don't care" for that field.
  task automatic expect_out(input int d, input string nm, input int st,
                            input int s0, input int s1, input int c);
    exp_t x;
    x.cyc = cyc; x.d = d; x.nm = nm; x.st = st; x.s0 = s0; x.s1 = s1; x.c = c;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input int d, input int act, input int expv);
    if (expv >= 0) begin
      n_chk++;
      if (act != expv) begin
        n_fail++;
        $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", nm, d, act, expv, cyc);
      end
    end
  endtask

  exp_t mx;
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        mx = q.pop_front();
        if (mx.cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s dut%0d: expectation for cycle %0d not checked, now %0d", mx.nm, mx.d, mx.cyc, cyc);
        end else begin
          chk({mx.nm, "_stall"}, mx.d, ost[mx.d],  mx.st);
          chk({mx.nm, "_sel0"},  mx.d, os0[mx.d],  mx.s0);
          chk({mx.nm, "_sel1"},  mx.d, os1[mx.d],  mx.s1);
          chk({mx.nm, "_cnt"},   mx.d, ocnt[mx.d], mx.c);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    instr(1, 0, 0, 2'b00, 5, 1, 0, 0);            // ADD x5 held during reset
    tick(); tick();

    reset = 1'b0;
    instr(1, 5, 5, 2'b11, 6, 1, 0, 0);            // ADD x6,x5,x5
    for (int d = 0; d < 3; d++) expect_out(d, "rst_state", 0, 0, 0, 0);
    tick();
    bubble();
    expect_out(0, "rst_no_load", 0, 0, 0, 0);
    tick();

    // back-to-back ALU dependency forwards from EX/MEM on both sources
    instr(1, 0, 0, 2'b00, 5, 1, 0, 0);
    expect_out(0, "t1_add", 0, -1, -1, -1);
    tick();
    instr(1, 5, 5, 2'b11, 6, 1, 0, 0);
    expect_out(0, "t1_dep", 0, -1, -1, -1);
    tick();
    bubble();
    expect_out(0, "t1_fwd", 0, 1, 1, 0);
    tick();

    // load-use: one stall, bubble in EX, then forward from stage 2
    instr(1, 0, 0, 2'b00, 5, 1, 1, 0);
    tick();
    instr(1, 5, 0, 2'b11, 7, 1, 0, 0);
    expect_out(0, "t2_stall", 1, -1, -1, 0);
    tick();
    expect_out(0, "t2_bubble", 0, 0, 0, 1);
    tick();
    bubble();
    expect_out(0, "t2_fwd", 0, 2, 0, 1);
    tick();

    // sources not read never match or stall
    instr(1, 0, 0, 2'b00, 5, 1, 1, 0);
    tick();
    instr(1, 5, 5, 2'b00, 9, 1, 0, 0);
    expect_out(0, "unused_stall", 0, -1, -1, -1);
    tick();
    bubble();
    expect_out(0, "unused_sel", -1, 0, 0, -1);
    tick();

    // youngest writer wins
    instr(1, 0, 0, 2'b00, 5, 1, 0, 0);
    tick();
    instr(1, 0, 0, 2'b00, 5, 1, 0, 0);
    tick();
    instr(1, 5, 0, 2'b01, 8, 1, 0, 0);
    expect_out(0, "t3_dep", 0, -1, -1, -1);
    tick();
    bubble();
    expect_out(0, "t3_youngest", -1, 1, 0, -1);
    tick();

    // x0 is never forwarded, even from a load
    instr(1, 0, 0, 2'b00, 0, 1, 1, 0);
    tick();
    instr(1, 0, 0, 2'b11, 10, 1, 0, 0);
    expect_out(0, "x0_stall", 0, -1, -1, 1);
    tick();
    bubble();
    expect_out(0, "x0_sel", 0, 0, 0, 1);
    tick();

    // source 1 from stage 2
    instr(1, 0, 0, 2'b00, 11, 1, 0, 0);
    tick();
    bubble();
    tick();
    instr(1, 0, 11, 2'b11, 12, 1, 0, 0);
    tick();
    bubble();
    expect_out(0, "src1_stage2", -1, 0, 2, -1);
    tick();

    // regwrite=0 does not forward
    instr(1, 0, 0, 2'b00, 13, 0, 0, 0);
    tick();
    instr(1, 13, 13, 2'b11, 14, 1, 0, 0);
    tick();
    bubble();
    expect_out(0, "nowrite_sel", -1, 0, 0, -1);
    tick();

    // DEPTH=4, ready at stage 3: two stall cycles then forward from stage 3
    instr(1, 0, 0, 2'b00, 5, 1, 1, 0);
    tick();
    instr(1, 5, 0, 2'b11, 7, 1, 0, 0);
    expect_out(1, "d4_stall1", 1, -1, -1, -1);
    tick();
    expect_out(1, "d4_stall2", 1, 0, 0, -1);
    tick();
    expect_out(1, "d4_go", 0, 0, 0, -1);
    tick();
    bubble();
    expect_out(1, "d4_fwd", 0, 3, 0, 4);
    tick();

    // flush during the stall window drops stall and loads nothing
    instr(1, 0, 0, 2'b00, 5, 1, 1, 0);
    tick();
    instr(1, 5, 0, 2'b11, 7, 1, 0, 0);
    expect_out(1, "fl_stall", 1, -1, -1, 4);
    tick();
    instr(1, 5, 0, 2'b11, 7, 1, 0, 1);
    expect_out(1, "fl_drop", 0, -1, -1, 5);
    tick();
    bubble();
    expect_out(1, "fl_sel", 0, 0, 0, 5);
    tick();

    // clean reset, then saturate the counter on the DEPTH=6 instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instr(1, 5, 0, 2'b01, 5, 1, 1, 0);            // LW x5,0(x5) repeated
    for (int d = 0; d < 3; d++) expect_out(d, "rst2_state", 0, 0, 0, 0);
    for (int i = 1; i <= 84001; i++) begin
      tick();
      if (i == 1)             expect_out(2, "sat_first", 1, -1, -1, 0);
      if (i == 6000)          expect_out(2, "sat_5000", 0, -1, -1, 5000);
      if (i == 6 * 13107)     expect_out(2, "sat_reach", 0, -1, -1, 65535);
      if (i == 6 * 13107 + 2) expect_out(2, "sat_hold", 1, -1, -1, 65535);
      if (i == 84000)         expect_out(2, "sat_end", 0, -1, -1, 65535);
      if (i == 84001) begin
        expect_out(2, "sat_midstall", 1, -1, -1, 65535);
        reset = 1'b1;
      end
    end
    tick();
    reset = 1'b0;
    for (int d = 0; d < 3; d++) expect_out(d, "rst3_state", 0, 0, 0, 0);
    tick();
    bubble();

    for (int i = 0; i < 5 && q.size() > 0; i++) tick();
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_BITS, default 5, register index width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands per instruction (1..4).
REQ-003 SHALL have parameter DEPTH, default 2, forwarding stages after EX (stage 1 = EX/MEM, stage DEPTH = last write-back stage), 1..6.
REQ-004 SHALL have parameter LOAD_READY_STAGE, default 2, first stage (1..DEPTH) at which load data can be forwarded.
REQ-005 SHALL derive SELW = clog2(DEPTH+1) as the forwarding-select width.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 id_valid  in  1  instruction present in ID.
REQ-009 id_rs  in  NUM_SRC*REG_BITS  source indices; source s at bits [s*REG_BITS +: REG_BITS].
REQ-010 id_rs_used  in  NUM_SRC  per-source "operand is read" flag.
REQ-011 id_rd, id_regwrite, id_is_load  in  REG_BITS, 1, 1  ID destination, write enable, load flag.
REQ-012 flush  in  1  kill the ID instruction (taken branch/jump resolved in EX).
REQ-013 stall  out  1  combinational: hold PC and IF/ID, insert bubble into EX.
REQ-014 fwd_sel  out  NUM_SRC*SELW  registered per-source select for the EX instruction; 0 = register file, k = stage k.
REQ-015 stall_count  out  16  saturating count of stall cycles.

Function
REQ-016 SHALL keep entries e[0..DEPTH], each {valid, rd, regwrite, is_load}; e[0] mirrors EX, e[k] mirrors stage k.
REQ-017 Every non-reset cycle SHALL shift e[k] <= e[k-1] for k = 1..DEPTH; the old e[DEPTH] is discarded (register file writes before reads in the same cycle).
REQ-018 e[0] SHALL load the ID instruction when id_valid && !stall && !flush; otherwise e[0] SHALL become a bubble (valid=0).
REQ-019 An entry SHALL match source s only when valid && regwrite && rd != 0 && rd == id_rs[s] && id_rs_used[s].
REQ-020 For each source, the youngest matching entry among e[0..DEPTH-1] (lowest index j) SHALL win; older matches are ignored.
REQ-021 On a cycle where e[0] loads from ID, fwd_sel[s] SHALL register j+1 for the winning entry, or 0 if none; otherwise fwd_sel SHALL register all zeros.
REQ-022 hazard SHALL be true if, for any source, the winning entry has is_load=1 and j+1 < LOAD_READY_STAGE.
REQ-023 stall SHALL equal id_valid && hazard && !flush; flush takes priority over stall.
REQ-024 stall SHALL stay high for consecutive cycles until the load reaches LOAD_READY_STAGE (LOAD_READY_STAGE-1 cycles when the load is in EX).
REQ-025 stall_count SHALL increment by 1 each cycle stall=1 and hold at 16'hFFFF.
REQ-026 rd = 0 SHALL never match, even with regwrite=1.

Reset
REQ-027 On reset all e[k].valid SHALL clear, fwd_sel SHALL be 0, and stall_count SHALL be 0; reset overrides flush and the ID inputs in the same cycle.
REQ-028 stall SHALL be 0 in the first cycle after reset regardless of ID inputs (no valid entries).

Structure
REQ-029 Package fwd_pkg SHALL hold default REG_BITS, the entry struct type, and the SELW width function.
REQ-030 Sub-module fwd_match (one per source, combinational priority match over DEPTH entries, returns select and is_load) SHALL be used; all state stays in fwd_hazard_ctrl.

Verification
REQ-031 Defaults; ADD x5 then ADD x6,x5,x5 back-to-back -> no stall; second instruction gets fwd_sel = {1,1}.
REQ-032 LW x5 then ADD x7,x5,x0 -> stall=1 for exactly 1 cycle, EX bubble, then fwd_sel[0]=2, fwd_sel[1]=0, stall_count=1.
REQ-033 ADD x5; ADD x5; ADD x8,x5 -> fwd_sel[0]=1 (youngest wins, not 2).
REQ-034 Write to x0 followed by read of x0 -> fwd_sel=0, no stall.
REQ-035 DEPTH=4, LOAD_READY_STAGE=3, load then dependent -> stall 2 cycles, then fwd_sel=3; with flush asserted during the stall -> stall drops same cycle, fwd_sel=0.
REQ-036 Force stall 70000 cycles -> stall_count saturates at 16'hFFFF; reset mid-stall -> all outputs 0 next cycle.
